tb_status_periph: RTL and testbench
===================================

TB_STATUS_PERIPH -- requirements
Module: tb_status_periph

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, stdout character FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter PASS_MAGIC, default 32'd123456789, STATUS write value meaning pass.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_req_i  input  1  core data request.
REQ-006 SHALL have port data_gnt_o  output  1  request accepted this cycle.
REQ-007 SHALL have port data_rvalid_o  output  1  response valid (reads and writes).
REQ-008 SHALL have port data_addr_i  input  32  byte address; only bits [3:2] decoded.
REQ-009 SHALL have port data_we_i  input  1  1 = write.
REQ-010 SHALL have port data_be_i  input  4  byte enables.
REQ-011 SHALL have port data_wdata_i  input  32  write data.
REQ-012 SHALL have port data_rdata_o  output  32  read data, valid with data_rvalid_o.
REQ-013 SHALL have port char_o  output  8  FIFO head character.
REQ-014 SHALL have port char_valid_o  output  1  FIFO non-empty.
REQ-015 SHALL have port char_ready_i  input  1  consumer pops head when high with char_valid_o.
REQ-016 SHALL have port tests_passed_o  output  1  sticky pass flag.
REQ-017 SHALL have port tests_failed_o  output  1  sticky fail flag.
REQ-018 SHALL have port exit_code_o  output  32  last EXIT write value.

Function
REQ-019 SHALL decode offsets: 0x0 PRINT, 0x4 STATUS, 0x8 EXIT, 0xC CYCLE.
REQ-020 SHALL drive data_gnt_o = data_req_i combinationally, except 0 for a PRINT write while FIFO count == FIFO_DEPTH (pop in same cycle does not lift the stall).
REQ-021 SHALL assert data_rvalid_o exactly one cycle after each grant, for one cycle, with data_rdata_o registered at grant.
REQ-022 SHALL on granted PRINT write with data_be_i[0]=1 push data_wdata_i[7:0]; be[0]=0 completes with no push.
REQ-023 SHALL on granted STATUS write set passed if data_wdata_i == PASS_MAGIC, else set failed.
REQ-024 SHALL on granted EXIT write load exit_code_o and set passed if data_wdata_i == 0, else failed.
REQ-025 SHALL make pass/fail first-wins: once either flag is set, later STATUS/EXIT writes change neither flag; exit_code_o still updates.
REQ-026 SHALL update flags and exit_code_o on the edge after grant (visible one cycle after grant).
REQ-027 SHALL return reads: PRINT 0; STATUS {30'b0, failed, passed}; EXIT exit_code_o; CYCLE counter value at grant edge.
REQ-028 SHALL ignore writes to CYCLE (response still given).
REQ-029 SHALL keep a free-running 32-bit cycle counter incrementing every cycle, wrapping 0xFFFFFFFF -> 0.
REQ-030 SHALL pop the FIFO when char_valid_o && char_ready_i; push and pop in one cycle leave count unchanged and preserve order.
REQ-031 SHALL hold char_o stable while char_valid_o=1 and char_ready_i=0; char_valid_o=0 when empty.
REQ-032 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with a separate count (0..FIFO_DEPTH).

Reset
REQ-033 SHALL on rst_i=1 immediately clear: data_rvalid_o, data_rdata_o, FIFO (count 0, pointers 0), char_valid_o, tests_passed_o, tests_failed_o, exit_code_o, cycle counter; char_o reads 0.
REQ-034 SHALL drop any in-flight response when reset asserts mid-transaction; no rvalid after reset release for a pre-reset grant.
REQ-035 SHALL hold data_gnt_o low while rst_i=1.

Verification
REQ-036 SHALL test: write 'H','i' to 0x0, char_ready_i=1 -> char_o 0x48 then 0x69, one rvalid per write.
REQ-037 SHALL test: char_ready_i=0, 9 PRINT writes -> 8 granted, 9th stalls gnt=0 until one pop, then granted next cycle.
REQ-038 SHALL test: write 123456789 to 0x4 -> tests_passed_o=1 one cycle after grant; then write 5 to 0x8 -> flags unchanged, exit_code_o=5.
REQ-039 SHALL test: write 3 to 0x8 from reset -> tests_failed_o=1, exit_code_o=3; read 0x4 returns 0x2.
REQ-040 SHALL test: read 0xC twice 10 cycles apart -> difference exactly 10; counter forced near 0xFFFFFFFF wraps to 0.
REQ-041 SHALL test: assert rst_i the cycle after a granted read -> no rvalid, all outputs zero, FIFO empty.

Source files
------------

// File: rtl/tb_status_periph.sv
// Simulation status peripheral: stdout character FIFO, sticky pass/fail flags,
// exit code register and a free-running cycle counter on a req/gnt/rvalid bus.
module tb_status_periph #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic [7:0]  char_o,
  output logic        char_valid_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic [31:0] exit_code_o
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] A_PRINT  = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_EXIT   = 2'd2;
  localparam logic [1:0] A_CYCLE  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic          r_rvalid, r_passed, r_failed;
  logic [31:0]   r_rdata, r_exit, r_cycle;

  logic [1:0]  w_sel;
  logic        w_full, w_wr, w_push, w_pop, w_decided, w_unused;
  logic [31:0] w_rd_val;

  assign w_sel     = data_addr_i[3:2];
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  // A pop in the stall cycle frees a slot only from the next cycle on.
  assign data_gnt_o = data_req_i & ~rst_i & ~(data_we_i & (w_sel == A_PRINT) & w_full);
  assign w_wr      = data_gnt_o & data_we_i;
  assign w_push    = w_wr & (w_sel == A_PRINT) & data_be_i[0];
  assign w_pop     = (r_count != '0) & char_ready_i;
  assign w_decided = r_passed | r_failed;
  assign w_unused  = ^{data_addr_i[31:4], data_addr_i[1:0], data_be_i[3:1]};

  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      A_STATUS: w_rd_val = {30'b0, r_failed, r_passed};
      A_EXIT:   w_rd_val = r_exit;
      A_CYCLE:  w_rd_val = r_cycle;
      default:  w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rd     <= '0;
      r_wr     <= '0;
      r_count  <= '0;
      r_passed <= 1'b0;
      r_failed <= 1'b0;
      r_exit   <= '0;
      r_cycle  <= '0;
    end else begin
      r_rvalid <= data_gnt_o;
      r_rdata  <= (data_gnt_o & ~data_we_i) ? w_rd_val : '0;
      r_cycle  <= r_cycle + 32'd1;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // First verdict wins; the exit code keeps tracking later writes.
      if (w_wr && (w_sel == A_STATUS) && !w_decided) begin
        r_passed <= (data_wdata_i == PASS_MAGIC);
        r_failed <= (data_wdata_i != PASS_MAGIC);
      end
      if (w_wr && (w_sel == A_EXIT)) begin
        r_exit <= data_wdata_i;
        if (!w_decided) begin
          r_passed <= (data_wdata_i == 32'd0);
          r_failed <= (data_wdata_i != 32'd0);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_wdata_i[7:0];
  end

  assign data_rvalid_o  = r_rvalid;
  assign data_rdata_o   = r_rdata;
  assign char_valid_o   = (r_count != '0);
  assign char_o         = (r_count != '0) ? r_mem[r_rd] : 8'h00;
  assign tests_passed_o = r_passed;
  assign tests_failed_o = r_failed;
  assign exit_code_o    = r_exit;
endmodule

// File: tb/tb_tb_status_periph.sv
// Bench for tb_status_periph: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model of the peripheral.
module tb_tb_status_periph;
  localparam int DEPTH = 8;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic clk = 1'b0, rst = 1'b1;
  logic req = 1'b0, we = 1'b0, ready = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] be = '0;
  logic gnt, rvalid, cvalid, passed, failed;
  logic [31:0] rdata, exitc;
  logic [7:0] chr;

  int total = 0, bad = 0;

  tb_status_periph #(.FIFO_DEPTH(DEPTH), .PASS_MAGIC(MAGIC)) dut (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rdata_o(rdata), .char_o(chr), .char_valid_o(cvalid), .char_ready_i(ready),
    .tests_passed_o(passed), .tests_failed_o(failed), .exit_code_o(exitc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  logic [7:0]  mq[$];
  logic        m_pass = 0, m_fail = 0, m_rvalid = 0, m_is_read = 0;
  logic [31:0] m_exit = '0, m_cyc = '0, m_rdata = '0;

  function automatic logic m_gnt();
    return req && !rst && !(we && addr[3:2] == 2'd0 && mq.size() == DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic g, pop;
    if (rst) begin
      mq.delete();
      m_pass = 0; m_fail = 0; m_rvalid = 0; m_is_read = 0;
      m_exit = '0; m_cyc = '0; m_rdata = '0;
    end else begin
      g = m_gnt();
      pop = (mq.size() > 0) && ready;
      m_rvalid = g;
      m_is_read = g && !we;
      if (g && !we) begin
        case (addr[3:2])
          2'd0: m_rdata = 32'd0;
          2'd1: m_rdata = {30'd0, m_fail, m_pass};
          2'd2: m_rdata = m_exit;
          default: m_rdata = m_cyc;
        endcase
      end
      if (g && we) begin
        case (addr[3:2])
          2'd0: if (be[0]) mq.push_back(wdata[7:0]);
          2'd1: if (!(m_pass || m_fail)) begin
                  if (wdata == MAGIC) m_pass = 1; else m_fail = 1;
                end
          2'd2: begin
                  m_exit = wdata;
                  if (!(m_pass || m_fail)) begin
                    if (wdata == 0) m_pass = 1; else m_fail = 1;
                  end
                end
          default: ;
        endcase
      end
      if (pop) void'(mq.pop_front());
      m_cyc = m_cyc + 1;
    end
  end

  // Per-cycle scoreboard, sampled mid-cycle
  logic       rec_en = 0;
  int         cnt_rv = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    #2;
    chk("gnt", {31'd0, gnt}, {31'd0, m_gnt()});
    chk("rvalid", {31'd0, rvalid}, {31'd0, m_rvalid});
    if (m_rvalid && m_is_read) chk("rdata", rdata, m_rdata);
    if (rst) chk("rdata_rst", rdata, 32'd0);
    chk("char_valid", {31'd0, cvalid}, {31'd0, mq.size() != 0});
    chk("char", {24'd0, chr}, {24'd0, (mq.size() != 0) ? mq[0] : 8'h00});
    chk("passed", {31'd0, passed}, {31'd0, m_pass});
    chk("failed", {31'd0, failed}, {31'd0, m_fail});
    chk("exit", exitc, m_exit);
    if (rec_en) begin
      if (rvalid) cnt_rv++;
      if (cvalid && ready) got_q.push_back(chr);
    end
  end

  task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] b, output logic [31:0] rd);
    int n;
    rd = '0;
    @(negedge clk);
    addr = a; we = w; wdata = wd; be = b; req = 1'b1;
    n = 0;
    #1;
    while (!gnt && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!gnt) begin
      chk("xact_timeout", 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("xact_rvalid", {31'd0, rvalid}, 32'd1);
    rd = rdata;
  endtask

  task automatic rst_pulse();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, c1, c2;
    // Reset state, and no grant while held in reset
    @(negedge clk);
    req = 1'b1; addr = 32'hC; we = 1'b0;
    #1;
    chk("gnt_in_rst", {31'd0, gnt}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_cvalid", {31'd0, cvalid}, 32'd0);
    chk("rst_char", {24'd0, chr}, 32'd0);
    chk("rst_flags", {30'd0, failed, passed}, 32'd0);
    chk("rst_exit", exitc, 32'd0);
    @(negedge clk); req = 1'b0; rst = 1'b0;

    // "Hi" streamed straight through
    ready = 1'b1; rec_en = 1'b1; cnt_rv = 0; got_q.delete();
    xact(32'h0, 1'b1, 32'h48, 4'h1, d);
    xact(32'h0, 1'b1, 32'h69, 4'h1, d);
    repeat (3) @(negedge clk);
    #3;
    rec_en = 1'b0;
    chk("hi_count", got_q.size(), 32'd2);
    chk("hi_0", {24'd0, (got_q.size() > 0) ? got_q[0] : 8'hFF}, 32'h48);
    chk("hi_1", {24'd0, (got_q.size() > 1) ? got_q[1] : 8'hFF}, 32'h69);
    chk("hi_rvalids", cnt_rv, 32'd2);

    // be[0]=0 completes without pushing
    ready = 1'b0;
    xact(32'h0, 1'b1, 32'h41, 4'hE, d);
    chk("be0_nopush", {31'd0, cvalid}, 32'd0);

    // Fill to depth, then the 9th write stalls until a pop has happened
    for (int i = 0; i < DEPTH; i++) xact(32'h0, 1'b1, 32'h30 + i, 4'h1, d);
    @(negedge clk);
    addr = 32'h0; we = 1'b1; wdata = 32'h58; be = 4'h1; req = 1'b1;
    #1 chk("full_stall", {31'd0, gnt}, 32'd0);
    repeat (2) begin
      @(negedge clk); #1 chk("full_hold", {31'd0, gnt}, 32'd0);
    end
    @(negedge clk); ready = 1'b1;
    #1 chk("stall_same_pop", {31'd0, gnt}, 32'd0);
    @(negedge clk); ready = 1'b0;
    #1 chk("gnt_after_pop", {31'd0, gnt}, 32'd1);
    @(negedge clk); req = 1'b0;
    ready = 1'b1;
    repeat (12) @(negedge clk);
    ready = 1'b0;

    // Pass via STATUS, then EXIT does not override the verdict
    rst_pulse();
    xact(32'h4, 1'b1, MAGIC, 4'hF, d);
    chk("pass_set", {31'd0, passed}, 32'd1);
    xact(32'h8, 1'b1, 32'd5, 4'hF, d);
    chk("pass_sticky", {30'd0, failed, passed}, 32'd1);
    chk("exit_5", exitc, 32'd5);

    // Fail via nonzero EXIT from reset
    rst_pulse();
    xact(32'h8, 1'b1, 32'd3, 4'hF, d);
    chk("fail_set", {31'd0, failed}, 32'd1);
    chk("exit_3", exitc, 32'd3);
    xact(32'h4, 1'b0, 32'd0, 4'hF, d);
    chk("status_rd", d, 32'h2);
    xact(32'h8, 1'b0, 32'd0, 4'hF, d);
    chk("exit_rd", d, 32'd3);
    xact(32'hC, 1'b1, 32'h1234, 4'hF, d);

    // Cycle counter: spacing and wrap
    xact(32'hC, 1'b0, 32'd0, 4'hF, c1);
    repeat (8) @(negedge clk);
    xact(32'hC, 1'b0, 32'd0, 4'hF, c2);
    chk("cyc_diff", c2 - c1, 32'd10);
    @(negedge clk);
    force dut.r_cycle = 32'hFFFF_FFF8;
    m_cyc = 32'hFFFF_FFF8;
    #1 release dut.r_cycle;
    xact(32'hC, 1'b0, 32'd0, 4'hF, c1);
    chk("cyc_prewrap", c1, 32'hFFFF_FFF9);
    repeat (8) @(negedge clk);
    xact(32'hC, 1'b0, 32'd0, 4'hF, c2);
    chk("cyc_wrap", c2, 32'd3);

    // Reset right after a granted read drops its response and clears state
    xact(32'h0, 1'b1, 32'h61, 4'h1, d);
    xact(32'h0, 1'b1, 32'h62, 4'h1, d);
    @(negedge clk);
    addr = 32'hC; we = 1'b0; req = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rvalid", {31'd0, rvalid}, 32'd0);
    chk("mid_rdata", rdata, 32'd0);
    chk("mid_cvalid", {31'd0, cvalid}, 32'd0);
    chk("mid_char", {24'd0, chr}, 32'd0);
    chk("mid_flags", {30'd0, failed, passed}, 32'd0);
    chk("mid_exit", exitc, 32'd0);
    @(negedge clk); req = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (2) begin
      @(negedge clk); #1 chk("post_rst_rvalid", {31'd0, rvalid}, 32'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 0) rst_pulse();
      @(negedge clk);
      req   = ($urandom_range(0, 3) != 0);
      addr  = $urandom();
      addr[3:2] = 2'($urandom_range(0, 3));
      we    = $urandom_range(0, 1);
      be    = 4'($urandom());
      case ($urandom_range(0, 3))
        0: wdata = MAGIC;
        1: wdata = 32'd0;
        default: wdata = $urandom();
      endcase
      ready = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk); req = 1'b0; ready = 1'b1;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
